// File: rtl/reduce_arb_pkg.sv
// Shared types and helpers for the reduce stream arbiter: token width,
// the done token that ends stream ownership, and the input FSM states.
package reduce_arb_pkg;

  localparam int DATA_W = 17;

  // Done token: control flag set, opcode field 01. Only this token ends a stream.
  localparam logic [DATA_W-1:0] DONE_TOKEN = 17'h10100;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // True when the token is exactly the done token (stop tokens do not match).
  function automatic logic is_done(input logic [DATA_W-1:0] tok);
    return (tok == DONE_TOKEN);
  endfunction

endpackage

// File: rtl/reduce_owner_fifo.sv
// Small id FIFO recording which requester owns each stream in flight through
// the reduce unit. Head is the owner of the tokens currently leaving the unit.
module reduce_owner_fifo
  import reduce_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int ID_W  = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            flush,
  input  logic            en,
  input  logic            push,
  input  logic [ID_W-1:0] push_id,
  input  logic            pop,
  output logic [ID_W-1:0] head,
  output logic            full,
  output logic            empty
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push_s;
  logic             do_pop_s;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_C) begin
      return '0;
    end else begin
      return p + 1'b1;
    end
  endfunction

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign head      = mem_q[rd_ptr_q];
  assign do_pop_s  = en & pop & ~empty;
  // Simultaneous push and pop on a full queue is legal: the pop frees the slot.
  assign do_push_s = en & push & (~full | do_pop_s);

  // Storage, pointers and occupancy count; flush empties the queue.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= push_id;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/reduce_stream_arbiter.sv
// Shares one reduce unit between NUM_REQ sparse token streams. A requester
// owns the input side from grant until its done token passes; result tokens
// are steered back through an owner queue so the next stream may start while
// the previous one is still draining.
module reduce_stream_arbiter
  import reduce_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 17,
  parameter int OWN_DEPTH = 2,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic              clk,
  input  logic              flush,
  input  logic              clk_en,
  input  logic              tile_en,
  input  logic [DATA_W-1:0] req_data_in [NUM_REQ],
  input  logic [NUM_REQ-1:0] req_data_in_valid,
  output logic [NUM_REQ-1:0] req_data_in_ready,
  output logic [DATA_W-1:0] req_data_out [NUM_REQ],
  output logic [NUM_REQ-1:0] req_data_out_valid,
  input  logic [NUM_REQ-1:0] req_data_out_ready,
  output logic [DATA_W-1:0] red_data_in,
  output logic              red_data_in_valid,
  input  logic              red_data_in_ready,
  input  logic [DATA_W-1:0] red_data_out,
  input  logic              red_data_out_valid,
  output logic              red_data_out_ready,
  output logic [ID_W-1:0]   grant_id,
  output logic              busy
);

  // After reset the search starts just past NUM_REQ-1, i.e. at requester 0.
  localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NUM_REQ - 1);

  arb_state_t      state_q;
  logic [ID_W-1:0] grant_id_q;
  logic [ID_W-1:0] last_grant_q;

  logic            active_s;
  logic            pick_found_s;
  logic [ID_W-1:0] pick_id_s;
  logic            grant_s;
  logic            in_done_s;
  logic            pop_s;
  logic [ID_W-1:0] out_id_s;
  logic            q_full_s;
  logic            q_empty_s;

  // Handshakes only complete while the tile is enabled and the clock is on.
  assign active_s = clk_en & tile_en;

  // Round-robin picker: first valid requester after the last grant, wrapping.
  always_comb begin
    logic [ID_W-1:0] cand;
    cand         = '0;
    pick_found_s = 1'b0;
    pick_id_s    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!pick_found_s && req_data_in_valid[cand]) begin
        pick_found_s = 1'b1;
        pick_id_s    = cand;
      end else begin
        pick_found_s = pick_found_s;
        pick_id_s    = pick_id_s;
      end
    end
  end

  // A full owner queue (registered count) blocks a new grant this cycle.
  assign grant_s   = active_s & (state_q == IDLE) & pick_found_s & ~q_full_s;
  assign in_done_s = red_data_in_valid & red_data_in_ready & is_done(red_data_in);
  assign pop_s     = red_data_out_valid & red_data_out_ready & is_done(red_data_out);

  // Input arbitration FSM: grant a stream and hold it until its done token passes.
  always_ff @(posedge clk) begin
    if (flush) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= LAST_INIT;
    end else if (active_s) begin
      case (state_q)
        IDLE: begin
          if (grant_s) begin
            state_q      <= GRANT;
            grant_id_q   <= pick_id_s;
            last_grant_q <= pick_id_s;
          end
        end
        GRANT: begin
          if (in_done_s) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  reduce_owner_fifo #(
    .DEPTH (OWN_DEPTH),
    .ID_W  (ID_W)
  ) u_owner_fifo (
    .clk     (clk),
    .flush   (flush),
    .en      (active_s),
    .push    (grant_s),
    .push_id (pick_id_s),
    .pop     (pop_s),
    .head    (out_id_s),
    .full    (q_full_s),
    .empty   (q_empty_s)
  );

  // Input mux: pass the owner's stream straight through to the reduce unit.
  always_comb begin
    red_data_in       = '0;
    red_data_in_valid = 1'b0;
    req_data_in_ready = '0;
    if (state_q == GRANT) begin
      red_data_in                   = req_data_in[grant_id_q];
      red_data_in_valid             = active_s & req_data_in_valid[grant_id_q];
      req_data_in_ready[grant_id_q] = active_s & red_data_in_ready;
    end else begin
      red_data_in       = '0;
      red_data_in_valid = 1'b0;
      req_data_in_ready = '0;
    end
  end

  // Output demux: results are broadcast; only the queue head sees valid.
  always_comb begin
    req_data_out_valid = '0;
    red_data_out_ready = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      req_data_out[r] = red_data_out;
    end
    if (!q_empty_s) begin
      req_data_out_valid[out_id_s] = active_s & red_data_out_valid;
      red_data_out_ready           = active_s & req_data_out_ready[out_id_s];
    end else begin
      req_data_out_valid = '0;
      red_data_out_ready = 1'b0;
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = (state_q == GRANT) | ~q_empty_s;

endmodule

// File: doc/reduce_stream_arbiter.md
# reduce_stream_arbiter

Shares one `reduce_pe_cluster` between `NUM_REQ` independent 17-bit sparse value streams. Each requester gets the reduce unit for a whole tensor stream, meaning every token up to and including its done token. Grants rotate round-robin. Reduced output tokens are routed back to the requester that owns them through an in-flight owner queue, so the input side can start the next stream while the previous one drains. The block sits between the GLB-side stream ports and the `reduce_data_*` ports of the cluster.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requester streams; must be ≥ 2.
- `DATA_W`, 17: token width. Bit 16 is the control flag.
- `OWN_DEPTH`, 2: number of streams that may be in flight (granted but done not yet seen at output).

Ports (clock/reset decision: one clock `clk`; reset is `flush`, synchronous, active-high):
- `clk` in 1: clock.
- `flush` in 1: synchronous active-high reset.
- `clk_en` in 1: when low, all state holds and no transfer completes.
- `tile_en` in 1: when low, all valid/ready outputs are 0 and state holds.
- `req_data_in[NUM_REQ]` in DATA_W: requester input tokens.
- `req_data_in_valid` in NUM_REQ: per-requester input valid.
- `req_data_in_ready` out NUM_REQ: per-requester input ready.
- `req_data_out[NUM_REQ]` out DATA_W: result tokens, broadcast to all requesters.
- `req_data_out_valid` out NUM_REQ: per-requester result valid.
- `req_data_out_ready` in NUM_REQ: per-requester result ready.
- `red_data_in` out DATA_W: token to reduce.
- `red_data_in_valid` out 1: valid to reduce.
- `red_data_in_ready` in 1: ready from reduce.
- `red_data_out` in DATA_W: token from reduce.
- `red_data_out_valid` in 1: valid from reduce.
- `red_data_out_ready` out 1: ready to reduce.
- `grant_id` out $clog2(NUM_REQ): current input owner.
- `busy` out 1: high in GRANT state or when the owner queue is non-empty.

## Operation
- Done token: `DATA_W'h10100`. Only the done token ends ownership; stop tokens (bit16=1, [9:8]=00) pass through unchanged.
- **Input FSM, IDLE:**
  - Candidates are requesters with `req_data_in_valid`=1.
  - Pick the first candidate after `last_grant`, round-robin and wrapping.
  - A grant requires the owner queue to be not full.
  - On grant: register `grant_id`, push the id into the owner queue, update `last_grant`, go to GRANT.
  - All `req_data_in_ready`=0 and `red_data_in_valid`=0 in IDLE.
- **Input FSM, GRANT:**
  - `red_data_in` = `req_data_in[grant_id]`.
  - `red_data_in_valid` = `req_data_in_valid[grant_id]`.
  - `req_data_in_ready[grant_id]` = `red_data_in_ready`; every other requester's ready is 0.
  - When a done token transfers (valid&ready), return to IDLE at the next edge.
- **Output routing:**
  - Owner queue head `out_id` selects the destination.
  - `req_data_out_valid[out_id]` = `red_data_out_valid`.
  - `red_data_out_ready` = `req_data_out_ready[out_id]`.
  - `req_data_out` = `red_data_out` for all requesters; only `out_id`'s valid may be high.
  - A done-token transfer at the output pops the queue.
  - Queue empty → `red_data_out_ready`=0 and all out valids 0.
- Unselected data outputs drive 0.

## Timing
- Reset (`flush`=1 at an edge):
  - FSM to IDLE, queue emptied, `last_grant`=NUM_REQ-1 so requester 0 has first priority.
  - `grant_id`=0, `busy`=0, and all valid/ready outputs read 0 the next cycle.
  - `flush` mid-stream drops ownership immediately; partial streams are not completed.
- Grant latency: requester valid seen in IDLE at edge N → ready may assert in cycle N+1. That is a 1-cycle bubble per stream, plus 1 bubble after a done token.
- The datapath is combinational pass-through. The block adds no register stage on data, valid or ready.
- Queue push and pop in the same cycle: count unchanged; legal even when the queue is full (the push decision uses the registered count, so a full queue blocks the grant that cycle).
- A done token entering and the same stream's done leaving in the same cycle are both honoured.
- Round-robin wrap: with `last_grant`=NUM_REQ-1, the search begins at 0.
- `clk_en`=0 or `tile_en`=0: no FSM, queue or `last_grant` update.

## Structure
- Package `reduce_arb_pkg`:
  - `DATA_W`
  - `DONE_TOKEN`
  - `is_done()` function
  - `arb_state_t` enum {IDLE, GRANT}
- Sub-module `reduce_owner_fifo`: OWN_DEPTH-entry id FIFO with push/pop/full/empty/head and a registered count.
- Top: input FSM plus round-robin picker, input mux, output demux.

## Test plan
- Reset, then requester 0 sends values 0x0003, 0x0005, stop 0x10000, done 0x10100 → all four tokens appear on `red_data_in` in order; the reduce result and done return only on `req_data_out_valid[0]`; `busy` falls after the output done.
- Requesters 1 and 2 valid simultaneously after reset → 1 is granted first, then 2; `grant_id` goes 1→2 with one IDLE bubble.
- All four requesters stream continuously → grant order is 0,1,2,3,0, with no starvation across 8 streams.
- Hold `req_data_out_ready[0]`=0 while requesters 0 and 1 complete input → requester 2 is not granted (queue full at OWN_DEPTH=2) until requester 0's output done pops.
- Assert `flush` mid-stream of requester 3 → next cycle all readies and valids are 0, the queue is empty, and the next grant goes to the lowest valid requester starting from 0.
- Randomized backpressure on both reduce ports with `clk_en` toggling → per-requester output token sequences match the golden reference, and no token is misrouted or duplicated.
